// File: rtl/udma_i2c_chan_arb_pkg.sv
// Shared opcode constants and arbiter state encodings for the uDMA I2C channel front-end.
package udma_i2c_pkg;

    localparam int unsigned I2C_OPC_W = 4;

    localparam logic [I2C_OPC_W-1:0] I2C_CMD_START   = 4'b0000;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_WAIT_EV = 4'b0001;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_STOP    = 4'b0010;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_RD_ACK  = 4'b0100;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_RD_NACK = 4'b0110;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_WR      = 4'b1000;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_EOT     = 4'b1001;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_WAIT    = 4'b1010;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_RPT     = 4'b1100;
    localparam logic [I2C_OPC_W-1:0] I2C_CMD_CFG     = 4'b1110;

    typedef logic [1:0] arb_state_e;

    localparam arb_state_e ST_IDLE  = 2'd0;
    localparam arb_state_e ST_OWNED = 2'd1;
    localparam arb_state_e ST_ABORT = 2'd2;

endpackage

// File: rtl/udma_i2c_chan_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping mod N.
module udma_i2c_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        int unsigned k;
        logic [IW-1:0] kk;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        kk    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr_i) + i;
            if (k >= N) k = k - N;
            kk = IW'(k);
            if (!any_o && req_i[kk]) begin
                any_o     = 1'b1;
                gnt_o[kk] = 1'b1;
                idx_o     = kk;
            end
        end
    end

endmodule

// File: rtl/udma_i2c_chan_arb.sv
// N-channel transaction-atomic arbiter in front of udma_i2c_control, with EOT/NACK routing
// and an idle watchdog that forces a STOP when the owner stalls.
module udma_i2c_chan_arb
    import udma_i2c_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CMD_W  = 32,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TO_W   = 16,
    localparam int unsigned OW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [TO_W-1:0]          cfg_timeout_i,
    input  logic [N_CH*CMD_W-1:0]    ch_cmd_i,
    input  logic [N_CH-1:0]          ch_cmd_valid_i,
    output logic [N_CH-1:0]          ch_cmd_ready_o,
    input  logic [N_CH*DATA_W-1:0]   ch_tx_i,
    input  logic [N_CH-1:0]          ch_tx_valid_i,
    output logic [N_CH-1:0]          ch_tx_ready_o,
    output logic [DATA_W-1:0]        ch_rx_o,
    output logic [N_CH-1:0]          ch_rx_valid_o,
    input  logic [N_CH-1:0]          ch_rx_ready_i,
    output logic [N_CH-1:0]          ch_eot_o,
    output logic [N_CH-1:0]          ch_nack_o,
    output logic [N_CH-1:0]          ch_timeout_o,
    output logic [CMD_W-1:0]         core_cmd_o,
    output logic                     core_cmd_valid_o,
    input  logic                     core_cmd_ready_i,
    output logic [DATA_W-1:0]        core_tx_o,
    output logic                     core_tx_valid_o,
    input  logic                     core_tx_ready_i,
    input  logic [DATA_W-1:0]        core_rx_i,
    input  logic                     core_rx_valid_i,
    output logic                     core_rx_ready_o,
    input  logic                     core_eot_i,
    input  logic                     core_nack_i,
    output logic [OW-1:0]            owner_o,
    output logic                     locked_o
);

    arb_state_e        state_q, state_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [N_CH-1:0]   owner_oh_q, owner_oh_d;
    logic [TO_W-1:0]   wdog_q, wdog_d;
    logic [N_CH-1:0]   eot_q, eot_d;
    logic [N_CH-1:0]   nack_q, nack_d;
    logic [N_CH-1:0]   to_q, to_d;

    logic [CMD_W-1:0]  cmd_arr [N_CH];
    logic [DATA_W-1:0] tx_arr  [N_CH];

    logic [N_CH-1:0]   pick_gnt;
    logic [OW-1:0]     pick_idx;
    logic              pick_any;
    logic [OW-1:0]     ptr_next;
    logic              hs;
    logic              wdog_hit;

    always_comb begin
        for (int unsigned k = 0; k < N_CH; k++) begin
            cmd_arr[k] = ch_cmd_i[k*CMD_W +: CMD_W];
            tx_arr[k]  = ch_tx_i[k*DATA_W +: DATA_W];
        end
    end

    udma_i2c_rr_pick #(
        .N  (N_CH),
        .IW (OW)
    ) u_pick (
        .req_i (ch_cmd_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign ptr_next = (owner_q == OW'(N_CH - 1)) ? '0 : owner_q + 1'b1;
    assign wdog_hit = (cfg_timeout_i != '0) && (wdog_q >= cfg_timeout_i);

    always_comb begin
        ch_cmd_ready_o   = '0;
        ch_tx_ready_o    = '0;
        ch_rx_valid_o    = '0;
        core_cmd_o       = '0;
        core_cmd_valid_o = 1'b0;
        core_tx_o        = '0;
        core_tx_valid_o  = 1'b0;
        core_rx_ready_o  = 1'b0;
        case (state_q)
            ST_OWNED: begin
                core_cmd_o       = cmd_arr[owner_q];
                core_cmd_valid_o = ch_cmd_valid_i[owner_q];
                ch_cmd_ready_o   = owner_oh_q & {N_CH{core_cmd_ready_i}};
                core_tx_o        = tx_arr[owner_q];
                core_tx_valid_o  = ch_tx_valid_i[owner_q];
                ch_tx_ready_o    = owner_oh_q & {N_CH{core_tx_ready_i}};
                ch_rx_valid_o    = owner_oh_q & {N_CH{core_rx_valid_i}};
                core_rx_ready_o  = ch_rx_ready_i[owner_q];
            end
            ST_ABORT: begin
                // Drain the core: RX is accepted and dropped while STOP is pending.
                core_cmd_o       = {I2C_CMD_STOP, {(CMD_W-I2C_OPC_W){1'b0}}};
                core_cmd_valid_o = 1'b1;
                core_rx_ready_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign hs = (core_cmd_valid_o & core_cmd_ready_i)
              | (core_tx_valid_o  & core_tx_ready_i)
              | (core_rx_valid_i  & core_rx_ready_o);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        wdog_d     = wdog_q;
        eot_d      = '0;
        nack_d     = '0;
        to_d       = '0;
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (pick_any) begin
                    owner_d    = pick_idx;
                    owner_oh_d = pick_gnt;
                    state_d    = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (core_nack_i) nack_d = owner_oh_q;
                // EOT outranks the watchdog; a handshake on the hit cycle cancels the abort.
                if (core_eot_i) begin
                    eot_d   = owner_oh_q;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else if (hs) begin
                    wdog_d = '0;
                end else if (wdog_hit) begin
                    state_d = ST_ABORT;
                end else if (wdog_q != '1) begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            ST_ABORT: begin
                if (core_eot_i) begin
                    eot_d   = owner_oh_q;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end else if (core_cmd_ready_i) begin
                    to_d    = owner_oh_q;
                    ptr_d   = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            owner_oh_q <= N_CH'(1);
            wdog_q     <= '0;
            eot_q      <= '0;
            nack_q     <= '0;
            to_q       <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            wdog_q     <= wdog_d;
            eot_q      <= eot_d;
            nack_q     <= nack_d;
            to_q       <= to_d;
        end
    end

    assign ch_rx_o      = core_rx_i;
    assign ch_eot_o     = eot_q;
    assign ch_nack_o    = nack_q;
    assign ch_timeout_o = to_q;
    assign owner_o      = owner_q;
    assign locked_o     = (state_q == ST_OWNED) || (state_q == ST_ABORT);

endmodule

// File: tb/tb_udma_i2c_chan_arb.sv
// Directed bench for udma_i2c_chan_arb: arbitration, pass-through, events, watchdog and reset.
module tb_udma_i2c_chan_arb;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned CMD_W  = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned TO_W   = 16;

    logic                   clk;
    logic                   rst;
    logic [TO_W-1:0]        cfg_timeout;
    logic [N_CH*CMD_W-1:0]  ch_cmd;
    logic [N_CH-1:0]        ch_cmd_valid, ch_cmd_ready;
    logic [N_CH*DATA_W-1:0] ch_tx;
    logic [N_CH-1:0]        ch_tx_valid, ch_tx_ready;
    logic [DATA_W-1:0]      ch_rx;
    logic [N_CH-1:0]        ch_rx_valid, ch_rx_ready;
    logic [N_CH-1:0]        ch_eot, ch_nack, ch_timeout;
    logic [CMD_W-1:0]       core_cmd;
    logic                   core_cmd_valid, core_cmd_ready;
    logic [DATA_W-1:0]      core_tx;
    logic                   core_tx_valid, core_tx_ready;
    logic [DATA_W-1:0]      core_rx;
    logic                   core_rx_valid, core_rx_ready;
    logic                   core_eot, core_nack;
    logic [1:0]             owner;
    logic                   locked;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    udma_i2c_chan_arb #(
        .N_CH   (N_CH),
        .CMD_W  (CMD_W),
        .DATA_W (DATA_W),
        .TO_W   (TO_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .cfg_timeout_i    (cfg_timeout),
        .ch_cmd_i         (ch_cmd),
        .ch_cmd_valid_i   (ch_cmd_valid),
        .ch_cmd_ready_o   (ch_cmd_ready),
        .ch_tx_i          (ch_tx),
        .ch_tx_valid_i    (ch_tx_valid),
        .ch_tx_ready_o    (ch_tx_ready),
        .ch_rx_o          (ch_rx),
        .ch_rx_valid_o    (ch_rx_valid),
        .ch_rx_ready_i    (ch_rx_ready),
        .ch_eot_o         (ch_eot),
        .ch_nack_o        (ch_nack),
        .ch_timeout_o     (ch_timeout),
        .core_cmd_o       (core_cmd),
        .core_cmd_valid_o (core_cmd_valid),
        .core_cmd_ready_i (core_cmd_ready),
        .core_tx_o        (core_tx),
        .core_tx_valid_o  (core_tx_valid),
        .core_tx_ready_i  (core_tx_ready),
        .core_rx_i        (core_rx),
        .core_rx_valid_i  (core_rx_valid),
        .core_rx_ready_o  (core_rx_ready),
        .core_eot_i       (core_eot),
        .core_nack_i      (core_nack),
        .owner_o          (owner),
        .locked_o         (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1;
        cfg_timeout = '0;
        ch_cmd = '0; ch_cmd_valid = '0;
        ch_tx = '0; ch_tx_valid = '0;
        ch_rx_ready = '0;
        core_cmd_ready = 1'b0; core_tx_ready = 1'b0;
        core_rx = '0; core_rx_valid = 1'b0;
        core_eot = 1'b0; core_nack = 1'b0;
        ch_cmd[1*CMD_W +: CMD_W] = 32'h8000_0011;
        ch_cmd[2*CMD_W +: CMD_W] = 32'h8000_0022;
        ch_tx[2*DATA_W +: DATA_W] = 8'h3C;
        steps(2);

        check("rst_owner", 64'(owner), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_cmd_valid", 64'(core_cmd_valid), 64'd0);
        check("rst_pulses", 64'({ch_eot, ch_nack, ch_timeout}), 64'd0);
        rst = 1'b0;

        // ch1+ch2 request: grant cycle passes nothing, then ch1 owns.
        ch_cmd_valid = 4'b0110;
        core_cmd_ready = 1'b1;
        #1;
        check("grant_cyc_ready", 64'(ch_cmd_ready), 64'd0);
        check("grant_cyc_valid", 64'(core_cmd_valid), 64'd0);
        step();
        check("t1_owner", 64'(owner), 64'd1);
        check("t1_locked", 64'(locked), 64'd1);
        check("t1_cmd", 64'(core_cmd), 64'h8000_0011);
        check("t1_cmd_valid", 64'(core_cmd_valid), 64'd1);
        check("t1_cmd_ready", 64'(ch_cmd_ready), 64'b0010);
        ch_cmd_valid = 4'b0100;
        #1;
        check("t1_ch2_blocked", 64'(ch_cmd_ready & 4'b0100), 64'd0);
        check("t1_no_valid", 64'(core_cmd_valid), 64'd0);
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;
        check("t1_eot_pulse", 64'(ch_eot), 64'b0010);
        check("t1_unlocked", 64'(locked), 64'd0);
        step();
        check("t1_eot_once", 64'(ch_eot), 64'd0);
        check("t1_owner2", 64'(owner), 64'd2);
        check("t1_cmd2", 64'(core_cmd), 64'h8000_0022);
        check("t1_cmd_ready2", 64'(ch_cmd_ready), 64'b0100);

        // RX/TX pass-through and NACK routing while ch2 owns.
        ch_cmd_valid = '0;
        core_cmd_ready = 1'b0;
        core_rx = 8'hA5;
        core_rx_valid = 1'b1;
        #1;
        check("rx_valid", 64'(ch_rx_valid), 64'b0100);
        check("rx_data", 64'(ch_rx), 64'hA5);
        check("rx_ready_lo", 64'(core_rx_ready), 64'd0);
        ch_rx_ready = 4'b0100;
        #1;
        check("rx_ready_hi", 64'(core_rx_ready), 64'd1);
        ch_rx_ready = 4'b1011;
        #1;
        check("rx_ready_other", 64'(core_rx_ready), 64'd0);
        core_rx_valid = 1'b0;
        ch_rx_ready = '0;
        ch_tx_valid = 4'b0100;
        core_tx_ready = 1'b1;
        #1;
        check("tx_data", 64'(core_tx), 64'h3C);
        check("tx_valid", 64'(core_tx_valid), 64'd1);
        check("tx_ready", 64'(ch_tx_ready), 64'b0100);
        ch_tx_valid = '0;
        core_tx_ready = 1'b0;
        core_nack = 1'b1;
        step();
        core_nack = 1'b0;
        check("nack_pulse", 64'(ch_nack), 64'b0100);
        check("nack_locked", 64'(locked), 64'd1);
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;
        check("t1_eot2", 64'(ch_eot), 64'b0100);

        // ptr=3: ch3 wins, then on release ch0 is granted by wrap.
        ch_cmd_valid = 4'b1001;
        step();
        check("wrap_owner3", 64'(owner), 64'd3);
        ch_cmd_valid = 4'b0001;
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;
        check("wrap_eot3", 64'(ch_eot), 64'b1000);
        step();
        check("wrap_owner0", 64'(owner), 64'd0);
        ch_cmd_valid = '0;
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;

        // Watchdog: ptr=1, ch1 stalls for 16 cycles, STOP is forced.
        cfg_timeout = 16'd16;
        ch_cmd_valid = 4'b0010;
        step();
        check("wd_owner", 64'(owner), 64'd1);
        ch_cmd_valid = '0;
        steps(16);
        check("wd_still_owned", 64'(locked), 64'd1);
        check("wd_no_stop_yet", 64'(core_cmd_valid), 64'd0);
        step();
        check("wd_stop_valid", 64'(core_cmd_valid), 64'd1);
        check("wd_stop_opc", 64'(core_cmd[31:28]), 64'h2);
        check("wd_stop_rest", 64'(core_cmd[27:0]), 64'd0);
        check("wd_abort_rx_rdy", 64'(core_rx_ready), 64'd1);
        check("wd_abort_cmd_rdy", 64'(ch_cmd_ready), 64'd0);
        step();
        check("wd_stop_held", 64'(core_cmd_valid), 64'd1);
        check("wd_abort_locked", 64'(locked), 64'd1);
        core_cmd_ready = 1'b1;
        step();
        core_cmd_ready = 1'b0;
        check("wd_timeout_pulse", 64'(ch_timeout), 64'b0010);
        check("wd_unlocked", 64'(locked), 64'd0);
        step();
        check("wd_timeout_once", 64'(ch_timeout), 64'd0);

        // EOT on the watchdog hit cycle: EOT only. ptr=2.
        cfg_timeout = 16'd4;
        ch_cmd_valid = 4'b0100;
        step();
        ch_cmd_valid = '0;
        steps(4);
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;
        check("hit_eot_pulse", 64'(ch_eot), 64'b0100);
        check("hit_eot_no_to", 64'(ch_timeout), 64'd0);
        check("hit_eot_unlocked", 64'(locked), 64'd0);
        step();
        check("hit_eot_no_to2", 64'(ch_timeout), 64'd0);

        // Handshake on the hit cycle cancels the abort. ptr=3.
        ch_cmd_valid = 4'b1000;
        step();
        ch_cmd_valid = '0;
        steps(4);
        ch_tx_valid = 4'b1000;
        core_tx_ready = 1'b1;
        step();
        ch_tx_valid = '0;
        core_tx_ready = 1'b0;
        check("hit_hs_locked", 64'(locked), 64'd1);
        check("hit_hs_no_stop", 64'(core_cmd_valid), 64'd0);
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;
        cfg_timeout = '0;

        // Reset mid-transfer clears ptr: ch2 then ch3 leave ptr=0 only after reset.
        ch_cmd_valid = 4'b0100;
        step();
        ch_cmd_valid = '0;
        core_eot = 1'b1;
        step();
        core_eot = 1'b0;
        ch_cmd_valid = 4'b1000;
        step();
        check("mid_owner3", 64'(owner), 64'd3);
        core_rx_valid = 1'b1;
        rst = 1'b1;
        step();
        check("mid_rst_locked", 64'(locked), 64'd0);
        check("mid_rst_owner", 64'(owner), 64'd0);
        check("mid_rst_cmd_valid", 64'(core_cmd_valid), 64'd0);
        check("mid_rst_ready", 64'(ch_cmd_ready), 64'd0);
        check("mid_rst_rx_valid", 64'(ch_rx_valid), 64'd0);
        core_rx_valid = 1'b0;
        rst = 1'b0;
        ch_cmd_valid = 4'b1010;
        step();
        check("post_rst_grant", 64'(owner), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
